// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU ops, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_LUI = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PCUP = 3'd5
  } state_e;

  // Instruction class: selects the phase sequence through the FSM
  typedef enum logic [2:0] {
    C_ALU = 3'd0,
    C_LW  = 3'd1,
    C_SW  = 3'd2,
    C_BEQ = 3'd3,
    C_J   = 3'd4,
    C_ILL = 3'd5
  } iclass_e;

endpackage

// File: rtl/idu_decode.sv
// Combinational instruction decoder: instr -> class, register fields, immediate, ALU controls.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: instr in; cls, rs/rt/rd, imm32, alu_op, alu_src, reg_dst, mem_to_reg, jaddr, illegal out.
module idu_decode
  import mips_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] instr,
  output iclass_e       cls,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [IW-1:0] imm32,
  output alu_op_e       alu_op,
  output logic          alu_src,
  output logic          reg_dst,
  output logic          mem_to_reg,
  output logic [27:0]   jaddr,
  output logic          illegal
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];

  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // Word-aligned jump offset within the current 256 MB region
  assign jaddr = {instr[25:0], 2'b00};

  always_comb begin
    cls        = C_ILL;
    imm32      = '0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          cls     = C_ALU;
          alu_op  = ALU_ADD;
          reg_dst = 1'b1;
        end else if (funct == FN_SUBU) begin
          cls     = C_ALU;
          alu_op  = ALU_SUB;
          reg_dst = 1'b1;
        end
      end
      OP_ORI: begin
        cls     = C_ALU;
        imm32   = IW'(imm16);
        alu_op  = ALU_OR;
        alu_src = 1'b1;
      end
      OP_LUI: begin
        cls     = C_ALU;
        imm32   = IW'({imm16, 16'h0000});
        alu_op  = ALU_LUI;
        alu_src = 1'b1;
      end
      OP_LW: begin
        cls        = C_LW;
        imm32      = {{(IW-16){imm16[15]}}, imm16};
        alu_op     = ALU_ADD;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        cls     = C_SW;
        imm32   = {{(IW-16){imm16[15]}}, imm16};
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
      end
      OP_BEQ: begin
        // Compare rs - rt; the immediate is the branch word offset for fetch
        cls     = C_BEQ;
        imm32   = {{(IW-16){imm16[15]}}, imm16};
        alu_op  = ALU_SUB;
      end
      OP_J: begin
        cls = C_J;
      end
      default: begin
        cls = C_ILL;
      end
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/idu.sv
// Multi-cycle decode/control sequencer: latches one instruction and walks it through DEC/EXEC/MEM/WB/PCUP.
// Latency: instr_valid to pc_update is 2 (J/illegal), 3 (BEQ), 4 (ALU/SW) or 5 (LW) cycles.
// Backpressure: none queued; instr_valid is dropped whenever busy (including the PCUP cycle).
// Ports: clk, reset (async, active-low); instr/instr_valid/pc/alu_zero in;
//        busy, rs/rt/rd, imm32, alu_op, alu_src, reg_we, reg_dst, mem_to_reg, mem_re/mem_we,
//        pc_w/pc_a/b_succ/wd/pc_update (PC command), illegal (sticky) out. All outputs registered.
module idu
  import mips_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  input  logic [IW-1:0] pc,
  input  logic          alu_zero,
  output logic          busy,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [IW-1:0] imm32,
  output logic [1:0]    alu_op,
  output logic          alu_src,
  output logic          reg_we,
  output logic          reg_dst,
  output logic          mem_to_reg,
  output logic          mem_re,
  output logic          mem_we,
  output logic          pc_w,
  output logic          pc_a,
  output logic          b_succ,
  output logic [IW-1:0] wd,
  output logic          pc_update,
  output logic          illegal
);

  // Keeps pc[31:28] when forming a jump target
  localparam logic [IW-1:0] PC_HI_MASK = {4'hF, {(IW-4){1'b0}}};

  state_e        state;
  state_e        state_nxt;
  logic [IW-1:0] instr_q;
  logic [IW-1:0] pc_q;

  iclass_e       d_cls;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [4:0]    d_rd;
  logic [IW-1:0] d_imm32;
  alu_op_e       d_alu_op;
  logic          d_alu_src;
  logic          d_reg_dst;
  logic          d_mem_to_reg;
  logic [27:0]   d_jaddr;
  logic          d_illegal;

  logic          pcup_nxt;
  logic [IW-1:0] j_target;
  logic [IW-1:0] wd_nxt;

  // The decoder looks at the latched word, so its outputs are stable for the
  // whole life of the instruction regardless of what fetch drives meanwhile.
  idu_decode #(.IW(IW)) u_decode (
    .instr      (instr_q),
    .cls        (d_cls),
    .rs         (d_rs),
    .rt         (d_rt),
    .rd         (d_rd),
    .imm32      (d_imm32),
    .alu_op     (d_alu_op),
    .alu_src    (d_alu_src),
    .reg_dst    (d_reg_dst),
    .mem_to_reg (d_mem_to_reg),
    .jaddr      (d_jaddr),
    .illegal    (d_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: each phase lasts exactly one cycle; the class picks the route
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          state_nxt = S_DEC;
        end
      end
      S_DEC: begin
        if (d_cls == C_J || d_cls == C_ILL) begin
          state_nxt = S_PCUP;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (d_cls == C_LW || d_cls == C_SW) begin
          state_nxt = S_MEM;
        end else if (d_cls == C_BEQ) begin
          state_nxt = S_PCUP;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (d_cls == C_LW) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_PCUP;
        end
      end
      S_WB:    state_nxt = S_PCUP;
      S_PCUP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pcup_nxt = (state_nxt == S_PCUP);
  assign j_target = (pc_q & PC_HI_MASK) | IW'(d_jaddr);

  always_comb begin
    wd_nxt = '0;
    if (pcup_nxt) begin
      if (d_cls == C_J) begin
        wd_nxt = j_target;
      end else if (d_cls == C_BEQ) begin
        wd_nxt = d_imm32;
      end
    end
  end

  // Output registers are loaded from the next state so that every strobe is
  // a flop output yet lines up with the phase it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= '0;
      pc_q       <= '0;
      busy       <= 1'b0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      imm32      <= '0;
      alu_op     <= '0;
      alu_src    <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      pc_w       <= 1'b0;
      pc_a       <= 1'b0;
      b_succ     <= 1'b0;
      wd         <= '0;
      pc_update  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        instr_q <= instr;
        pc_q    <= pc;
      end

      if (state == S_DEC) begin
        rs         <= d_rs;
        rt         <= d_rt;
        rd         <= d_rd;
        imm32      <= d_imm32;
        alu_op     <= d_alu_op;
        alu_src    <= d_alu_src;
        reg_dst    <= d_reg_dst;
        mem_to_reg <= d_mem_to_reg;
        if (d_illegal) begin
          illegal <= 1'b1;
        end
      end

      busy      <= (state_nxt != S_IDLE);
      reg_we    <= (state_nxt == S_WB);
      mem_re    <= (state_nxt == S_MEM) && (d_cls == C_LW);
      mem_we    <= (state_nxt == S_MEM) && (d_cls == C_SW);
      pc_update <= pcup_nxt;
      pc_w      <= pcup_nxt && (d_cls == C_J);
      pc_a      <= pcup_nxt && (d_cls == C_BEQ);
      // BEQ enters PCUP only from EXEC, so this captures alu_zero from the
      // last EXEC cycle and doubles as the branch-taken flag.
      b_succ    <= pcup_nxt && (d_cls == C_BEQ) && alu_zero;
      wd        <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_idu.sv
module tb_idu;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        alu_zero;
  logic        busy;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm32;
  logic [1:0]  alu_op;
  logic        alu_src, reg_we, reg_dst, mem_to_reg, mem_re, mem_we;
  logic        pc_w, pc_a, b_succ, pc_update, illegal;
  logic [31:0] wd;

  idu #(.IW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .alu_zero    (alu_zero),
    .busy        (busy),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm32       (imm32),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .reg_we      (reg_we),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .pc_w        (pc_w),
    .pc_a        (pc_a),
    .b_succ      (b_succ),
    .wd          (wd),
    .pc_update   (pc_update),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one accepted instruction
  typedef struct {
    int          issue;
    int          lat;
    bit          pcw, pca, bs, ill, chkf;
    logic [31:0] wd;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [1:0]  aop;
    bit          asrc, rdst, m2r;
    int          nre, nwe, nrw;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   ill_model = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input bit z, input bit ill_in);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [31:0] sext;
    op   = i[31:26];
    fn   = i[5:0];
    im   = i[15:0];
    sext = {{16{im[15]}}, im};
    e = '{issue: 0, lat: 2, pcw: 0, pca: 0, bs: 0, ill: ill_in, chkf: 1, wd: 32'h0,
          rs: i[25:21], rt: i[20:16], rd: i[15:11], imm: 32'h0, aop: 2'd0,
          asrc: 0, rdst: 0, m2r: 0, nre: 0, nwe: 0, nrw: 0};
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      e.lat = 4; e.nrw = 1; e.rdst = 1; e.aop = (fn == 6'h21) ? 2'd0 : 2'd1;
    end else if (op == 6'h0d) begin
      e.lat = 4; e.nrw = 1; e.asrc = 1; e.aop = 2'd2; e.imm = {16'h0, im};
    end else if (op == 6'h0f) begin
      e.lat = 4; e.nrw = 1; e.asrc = 1; e.aop = 2'd3; e.imm = {im, 16'h0};
    end else if (op == 6'h23) begin
      e.lat = 5; e.nre = 1; e.nrw = 1; e.asrc = 1; e.m2r = 1; e.imm = sext;
    end else if (op == 6'h2b) begin
      e.lat = 4; e.nwe = 1; e.asrc = 1; e.imm = sext;
    end else if (op == 6'h04) begin
      e.lat = 3; e.pca = 1; e.bs = z; e.aop = 2'd1; e.imm = sext; e.wd = sext;
    end else if (op == 6'h02) begin
      e.lat = 2; e.pcw = 1; e.chkf = 0; e.wd = {p[31:28], i[25:0], 2'b00};
    end else begin
      e.lat = 2; e.ill = 1; e.chkf = 0;
    end
    return e;
  endfunction

  // Monitor: counts strobes per instruction, checks against the scoreboard on pc_update
  int   m_re = 0, m_we = 0, m_rw = 0;
  exp_t r;
  always @(negedge clk) begin
    if (!reset) begin
      m_re = 0; m_we = 0; m_rw = 0;
    end else begin
      m_re += int'(mem_re);
      m_we += int'(mem_we);
      m_rw += int'(reg_we);
      if (pc_update) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pc_update: got pc_update=1, expected no pending instruction (t=%0t)", $time);
        end else begin
          r = sb.pop_front();
          chk("latency", cyc - r.issue, r.lat);
          chk("busy_in_pcup", busy, 1);
          chk("pc_w", pc_w, r.pcw);
          chk("pc_a", pc_a, r.pca);
          chk("b_succ", b_succ, r.bs);
          chk("wd", wd, r.wd);
          chk("illegal", illegal, r.ill);
          chk("n_mem_re", m_re, r.nre);
          chk("n_mem_we", m_we, r.nwe);
          chk("n_reg_we", m_rw, r.nrw);
          if (r.chkf) begin
            chk("rs", rs, r.rs);
            chk("rt", rt, r.rt);
            chk("rd", rd, r.rd);
            chk("imm32", imm32, r.imm);
            chk("alu_op", alu_op, r.aop);
            chk("alu_src", alu_src, r.asrc);
            chk("reg_dst", reg_dst, r.rdst);
            chk("mem_to_reg", mem_to_reg, r.m2r);
          end
        end
        m_re = 0; m_we = 0; m_rw = 0;
      end else begin
        chk("pccmd_idle", {pc_w, pc_a, b_succ, |wd}, 0);
        if (sb.size() > 0 && (cyc - sb[0].issue) > 12) begin
          n_cmp++; n_err++;
          $display("FAIL pc_update_timeout: got none after %0d cycles, expected one at %0d", cyc - sb[0].issue, sb[0].lat);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the unit to go idle, then presents one instruction for one cycle
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input bit z);
    exp_t e;
    int   w = 0;
    while (busy && w < 20) begin
      step();
      w++;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL busy_wait: got busy=1 after 20 cycles, expected 0");
    end
    e = model(i, p, z, ill_model);
    ill_model = e.ill;
    e.issue = cyc;
    sb.push_back(e);
    instr = i; pc = p; alu_zero = z; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = $urandom;
    pc    = $urandom;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, pc_update, pc_w, pc_a, b_succ, reg_we, mem_re, mem_we,
                        illegal, alu_src, reg_dst, mem_to_reg, alu_op}, 0);
    chk({tag, "_regs"}, {rs, rt, rd}, 0);
    chk({tag, "_imm32"}, imm32, 0);
    chk({tag, "_wd"}, wd, 0);
  endtask

  initial begin
    logic [4:0]  a, b, c;
    logic [15:0] im;
    logic [31:0] w;
    int          k, tmo;

    reset = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; alu_zero = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("reset_async");
    repeat (2) step();
    chk_zero("reset_held");
    reset = 1'b1;
    repeat (2) step();
    chk("idle_after_reset", {busy, pc_update}, 0);

    // Directed cases
    issue(32'h00228021, 32'h00400000, 0);   // ADDU
    issue(32'h00228023, 32'h00400004, 1);   // SUBU
    issue(32'h34320080, 32'h00400008, 0);   // ORI
    issue(32'h3c14abcd, 32'h0040000c, 0);   // LUI
    issue(32'h8c330002, 32'h00400010, 0);   // LW
    issue(32'hac310002, 32'h00400014, 0);   // SW
    issue(32'h1042ffe0, 32'h00400018, 1);   // BEQ taken
    issue(32'h1042ffe0, 32'h0040001c, 0);   // BEQ not taken
    issue(32'h08000004, 32'h10000000, 0);   // J
    issue(32'hffffffff, 32'h00400020, 0);   // illegal, sets sticky flag
    issue(32'h00228021, 32'h00400024, 0);   // flag stays set

    // Reset during LW MEM: abandoned, everything clears at once
    issue(32'h8c330002, 32'h00400028, 0);
    tmo = 0;
    while (!mem_re && tmo < 10) begin
      step();
      tmo++;
    end
    chk("lw_reached_mem", mem_re, 1);
    reset = 1'b0;
    #1 chk_zero("reset_mid_lw");
    sb.delete();
    ill_model = 1'b0;
    step(); step();
    reset = 1'b1;
    repeat (8) step();

    // Pulse while in DEC: ignored
    issue(32'h00228021, 32'h00400030, 0);
    instr = 32'h08000004; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    // Pulse in the PCUP cycle: ignored
    issue(32'h1042ffe0, 32'h00400034, 1);
    tmo = 0;
    while (!pc_update && tmo < 10) begin
      step();
      tmo++;
    end
    chk("beq_reached_pcup", pc_update, 1);
    instr = 32'h34320080; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    repeat (6) step();
    chk("no_capture_from_ignored", busy, 0);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      a  = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      im = 16'($urandom);
      k  = $urandom_range(0, 8);
      case (k)
        0: w = {6'h00, a, b, c, 5'($urandom), 6'h21};
        1: w = {6'h00, a, b, c, 5'($urandom), 6'h23};
        2: w = {6'h0d, a, b, im};
        3: w = {6'h0f, a, b, im};
        4: w = {6'h23, a, b, im};
        5: w = {6'h2b, a, b, im};
        6: w = {6'h04, a, b, im};
        7: w = {6'h02, 26'($urandom)};
        default: w = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) step();
      issue(w, $urandom, 1'($urandom_range(0, 1)));
    end

    tmo = 0;
    while (sb.size() != 0 && tmo < 30) begin
      step();
      tmo++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idu.md
# idu

Multi-cycle instruction decode and control sequencer for the MIPS core. It sits directly downstream of the instruction fetch unit and latches each fetched instruction word. It steps the instruction through EXEC/MEM/WB phases, driving register-file, ALU and data-memory strobes. It finishes each instruction with a one-cycle PC-update command (`pc_w`, `pc_a`, `b_succ`, `wd`) back to the fetch unit.

## Interface
- `IW`, default 32: instruction and data width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `instr`  in  IW  instruction word from fetch.
- `instr_valid`  in  1  one-cycle strobe: `instr` is valid.
- `pc`  in  IW  current PC of `instr`.
- `alu_zero`  in  1  ALU result == 0.
- `busy`  out  1  high from capture until the PCUP cycle inclusive.
- `rs`, `rt`, `rd`  out  5 each  register addresses.
- `imm32`  out  IW  extended immediate.
- `alu_op`  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI.
- `alu_src`  out  1  1 = ALU B operand is `imm32`.
- `reg_we`  out  1  register write strobe.
- `reg_dst`  out  1  1 = write `rd`, 0 = write `rt`.
- `mem_to_reg`  out  1  write-back data comes from memory.
- `mem_re`, `mem_we`  out  1 each  data-memory strobes.
- `pc_w`, `pc_a`, `b_succ`  out  1 each  PC commands to fetch.
- `wd`  out  IW  PC-command operand.
- `pc_update`  out  1  one-cycle strobe: PC command valid.
- `illegal`  out  1  sticky: an unsupported opcode/funct was seen.

## Operation
- Decoding:
  - R-type: op 000000, funct 100001 ADDU, funct 100011 SUBU.
  - ORI 001101: `imm32` zero-extended.
  - LUI 001111: `imm32` = {imm, 16'h0}.
  - LW 100011 and SW 101011: `imm32` sign-extended, ALU ADD.
  - BEQ 000100: `imm32` sign-extended, ALU SUB.
  - J 000010.
  - Anything else is illegal.
- States: IDLE, DEC, EXEC, MEM, WB, PCUP.
- Transitions:
  - IDLE→DEC on `instr_valid`; instruction and `pc` are latched.
  - ADDU/SUBU/ORI/LUI: DEC→EXEC→WB→PCUP.
  - LW: DEC→EXEC→MEM→WB→PCUP.
  - SW: DEC→EXEC→MEM→PCUP.
  - BEQ: DEC→EXEC→PCUP.
  - J and illegal: DEC→PCUP.
  - PCUP→IDLE unconditionally.
- Decoded fields (`rs`/`rt`/`rd`/`imm32`/`alu_op`/`alu_src`/`reg_dst`/`mem_to_reg`) are registered in DEC and held stable until the next capture.
- Strobes:
  - `mem_re` high only in MEM for LW; `mem_we` high only in MEM for SW.
  - `reg_we` high only in WB.
- BEQ: `alu_zero` is sampled on the last EXEC cycle into a branch-taken flag.
- PCUP for BEQ: `pc_a`=1, `b_succ`=flag, `wd`=`imm32` (fetch scales by 4).
- PCUP for J: `pc_w`=1, `wd`={pc[31:28], instr[25:0], 2'b00}.
- PCUP for all others: `pc_w`=`pc_a`=`b_succ`=0, `wd`=0 (sequential PC+4).
- Illegal: sets `illegal`, which is cleared only by reset. The instruction is otherwise a no-op with a sequential PC.

## Timing
- Reset is asserted asynchronously. Every output goes to 0, state goes to IDLE, and the latched instruction goes to 0. Deassertion takes effect at the next `clk` edge.
- Reset mid-instruction: the instruction is abandoned; no `pc_update` and no further strobes.
- Each state lasts exactly one cycle. `instr_valid` rise to `pc_update` takes:
  - ALU-class: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - J/illegal: 2 cycles.
- `instr_valid` while `busy` is ignored; no queueing.
- `instr_valid` in the same cycle as PCUP is ignored. Fetch must pulse at least one cycle after `pc_update`.
- `pc_w`, `pc_a`, `b_succ` and `wd` are valid only while `pc_update`=1 and are 0 otherwise.
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - ALU-op encodings;
  - state encoding (3-bit enum).
- Sub-module `idu_decode` is purely combinational. It maps instr → instruction class, fields, `imm32`, `alu_op`/`alu_src`/`reg_dst`/`mem_to_reg` and illegal.
- `idu` holds the FSM, latches and output registers.

## Test plan
- ADDU: `instr`=0x00228021 → `rs`=1, `rt`=2, `rd`=16, `alu_op`=ADD, `reg_dst`=1. `reg_we` pulses in cycle 3; `pc_update` in cycle 4 with `pc_w`=`pc_a`=0.
- ORI: 0x34320080 → `rt`=18, `imm32`=0x00000080, `alu_src`=1. LUI: 0x3c14abcd → `imm32`=0xabcd0000, `alu_op`=3.
- LW: 0x8c330002 → `mem_re` in MEM, then `reg_we` with `mem_to_reg`=1, `pc_update` at cycle 5. SW: 0xac310002 → `mem_we` only, no `reg_we`.
- BEQ: 0x1042ffe0 with `alu_zero`=1 → `pc_a`=1, `b_succ`=1, `wd`=0xffffffe0. With `alu_zero`=0 → `b_succ`=0.
- Illegal: 0xffffffff → `illegal`=1 sticky, `pc_update` at cycle 2 sequential. J 0x08000004 with `pc`=0x10000000 → `pc_w`=1, `wd`=0x10000010.
- Reset low during LW MEM → all outputs 0 at once, no `pc_update`. A second `instr_valid` while `busy` → ignored.
